// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch slice: word width, opcode constants
// and the fetch-stage state encoding.
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/mips_next_pc.sv
// Purely combinational next-PC selection: sequential, branch, immediate jump
// and register jump targets, plus the pc+4 link value.
module mips_next_pc
    import mips_pkg::*;
(
    input  logic [WORD_W-1:0] pc,
    input  logic [25:0]       instr_index,
    input  logic              PCSrc,
    input  logic              PCsignal,
    input  logic              jumpSrc,
    input  logic [WORD_W-1:0] jr_target,
    output logic [WORD_W-1:0] pc_plus4,
    output logic [WORD_W-1:0] next_pc
);

    logic [WORD_W-1:0] branch_offset;
    logic [WORD_W-1:0] jump_target;

    assign pc_plus4      = pc + 32'd4;
    assign branch_offset = {{14{instr_index[15]}}, instr_index[15:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], instr_index, 2'b00};

    // Jump-class decisions take precedence over a taken branch.
    always_comb begin
        next_pc = pc_plus4;
        if (PCsignal) begin
            next_pc = jumpSrc ? jump_target : jr_target;
        end else if (PCSrc) begin
            next_pc = pc_plus4 + branch_offset;
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ready handshake,
// holds the instruction for the controller and retires it on exec_done.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus4,
    input  logic              exec_done,
    input  logic              PCSrc,
    input  logic              PCsignal,
    input  logic              jumpSrc,
    input  logic [WORD_W-1:0] jr_target,
    output logic [CNT_W-1:0]  retired
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [WORD_W-1:0] next_pc;

    mips_next_pc u_next_pc (
        .pc          (pc),
        .instr_index (instr[25:0]),
        .PCSrc       (PCSrc),
        .PCsignal    (PCsignal),
        .jumpSrc     (jumpSrc),
        .jr_target   (jr_target),
        .pc_plus4    (pc_plus4),
        .next_pc     (next_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            instr   <= '0;
            retired <= '0;
        end else begin
            state <= state_next;
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        instr <= imem_rdata;
                    end
                end
                HOLD: begin
                    if (exec_done) begin
                        pc      <= next_pc;
                        retired <= retired + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (imem_ready) state_next = HOLD;
            HOLD:    if (exec_done)  state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // The request is held low during reset so no response can race the PC reload.
    assign imem_req    = (state == FETCH) && !rst;
    assign imem_addr   = pc;
    assign instr_valid = (state == HOLD);

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: directed scenarios followed by
// randomized traffic against a behavioural instruction-level reference model.
module tb_mips_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        exec_done;
    logic        PCSrc;
    logic        PCsignal;
    logic        jumpSrc;
    logic [31:0] jr_target;
    logic [31:0] retired;

    int compareCount;
    int mismatchCount;

    // Reference model state
    logic [31:0] mPc;
    logic [31:0] mInstr;
    logic        mHolding;
    logic [31:0] mRetired;

    mips_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .exec_done   (exec_done),
        .PCSrc       (PCSrc),
        .PCsignal    (PCsignal),
        .jumpSrc     (jumpSrc),
        .jr_target   (jr_target),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Architectural target computed from the ISA definition of each control class.
    function automatic logic [31:0] refNextPc(input logic [31:0] curPc, input logic [31:0] word,
                                              input logic br, input logic jmp, input logic imm,
                                              input logic [31:0] regTarget);
        logic [31:0] seq;
        int          offsetWords;
        seq = curPc + 32'd4;
        if (jmp && imm)  return (seq & 32'hF000_0000) | (32'(word[25:0]) * 32'd4);
        if (jmp)         return regTarget;
        if (br) begin
            offsetWords = int'($signed(word[15:0]));
            return seq + 32'(offsetWords * 4);
        end
        return seq;
    endfunction

    task automatic applyStimulus(input logic r, input logic rdy, input logic [31:0] rdata,
                                 input logic done, input logic br, input logic jmp,
                                 input logic imm, input logic [31:0] regTarget);
        @(negedge clk);
        rst        = r;
        imem_ready = rdy;
        imem_rdata = rdata;
        exec_done  = done;
        PCSrc      = br;
        PCsignal   = jmp;
        jumpSrc    = imm;
        jr_target  = regTarget;
        #1;
        checkOutput("imem_req",    32'(imem_req),    32'(!mHolding && !r));
        checkOutput("imem_addr",   imem_addr,        mPc);
        checkOutput("pc",          pc,               mPc);
        checkOutput("pc_plus4",    pc_plus4,         mPc + 32'd4);
        checkOutput("instr_valid", 32'(instr_valid), 32'(mHolding));
        checkOutput("instr",       instr,            mInstr);
        checkOutput("retired",     retired,          mRetired);
        @(posedge clk);
        if (r) begin
            mPc      = 32'h0;
            mInstr   = 32'h0;
            mHolding = 1'b0;
            mRetired = 32'h0;
        end else if (!mHolding) begin
            if (rdy) begin
                mInstr   = rdata;
                mHolding = 1'b1;
            end
        end else if (done) begin
            mPc      = refNextPc(mPc, mInstr, br, jmp, imm, regTarget);
            mRetired = mRetired + 32'd1;
            mHolding = 1'b0;
        end
    endtask

    // One fetch cycle with ready, then one hold cycle with exec_done and the given controls.
    task automatic runInstr(input logic [31:0] word, input logic br, input logic jmp,
                            input logic imm, input logic [31:0] regTarget);
        applyStimulus(1'b0, 1'b1, word, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, $urandom, 1'b1, br, jmp, imm, regTarget);
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        mPc      = 32'h0;
        mInstr   = 32'h0;
        mHolding = 1'b0;
        mRetired = 32'h0;
        rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0; exec_done = 1'b0;
        PCSrc = 1'b0; PCsignal = 1'b0; jumpSrc = 1'b0; jr_target = '0;

        // Reset for two cycles (first edge establishes the model's reset state too)
        @(posedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("reset_pc", pc, 32'h0);
        checkOutput("reset_retired", retired, 32'h0);

        // Sequential fetch with a wait-state at pc=8
        runInstr(32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0);
        runInstr(32'h0000_0002, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'hBAD0_0000 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            #1;
            checkOutput("wait_addr", imem_addr, 32'h8);
            checkOutput("wait_req", 32'(imem_req), 32'h1);
            checkOutput("wait_instr", instr, 32'h0000_0002);
        end
        runInstr(32'h0000_0003, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("seq_retired", retired, 32'd3);
        checkOutput("seq_addr", imem_addr, 32'hC);

        // Backward branch taken from pc=16, then not taken
        runInstr(32'h0000_0004, 1'b0, 1'b0, 1'b0, 32'h0);
        runInstr(32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("branch_taken", imem_addr, 32'hC);
        runInstr(32'h0000_0005, 1'b0, 1'b0, 1'b0, 32'h0);
        runInstr(32'h1000_FFFE, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("branch_not_taken", imem_addr, 32'h14);

        // Immediate jump within the 0x1000_0000 region, then register jump
        runInstr(32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h1000_0000);
        runInstr(32'h0800_0040, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        #1;
        checkOutput("j_target", imem_addr, 32'h1000_0100);
        runInstr(32'h0000_0008, 1'b1, 1'b1, 1'b0, 32'h0000_0200);
        #1;
        checkOutput("jr_target", imem_addr, 32'h200);

        // Jump overrides a taken branch; pc wraps past the top of memory
        runInstr(32'h1000_0010, 1'b1, 1'b1, 1'b0, 32'h40);
        #1;
        checkOutput("priority", imem_addr, 32'h40);
        runInstr(32'h0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
        runInstr(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("wrap", imem_addr, 32'h0);

        // Reset while holding at pc=0x80, then reset during a ready fetch
        runInstr(32'h0, 1'b0, 1'b1, 1'b0, 32'h80);
        applyStimulus(1'b0, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h999);
        #1;
        checkOutput("rst_hold_pc", pc, 32'h0);
        checkOutput("rst_hold_valid", 32'(instr_valid), 32'h0);
        checkOutput("rst_hold_retired", retired, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("rst_fetch_instr", instr, 32'h0);
        checkOutput("rst_fetch_valid", 32'(instr_valid), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 99) < 2),
                          ($urandom_range(0, 9) < 7),
                          $urandom,
                          ($urandom_range(0, 9) < 6),
                          1'($urandom),
                          ($urandom_range(0, 3) == 0),
                          1'($urandom),
                          $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- Instruction-fetch and next-PC stage directly upstream of the MIPS main controller.
- Holds the program counter and fetches from an instruction memory with variable latency, using a req/ready handshake.
- Presents the opcode/funct fields to the controller, then consumes the controller's PCSrc/PCsignal/jumpSrc decision to form the next PC.
- Also produces PC+4 for the jal link path and counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc.
- imem_ready  in  1  memory has rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  held instruction; opCode=instr[31:26], functionCode=instr[5:0].
- instr_valid  out  1  instr is stable and the controller outputs are meaningful.
- pc  out  32  address of the held instruction.
- pc_plus4  out  32  pc+4, used as the jal link value.
- exec_done  in  1  the execute/writeback side has completed the held instruction.
- PCSrc  in  1  branch taken (from the controller).
- PCsignal  in  1  jump-class instruction (from the controller).
- jumpSrc  in  1  1 = j/jal immediate target, 0 = register target.
- jr_target  in  32  register-file read data used for register jumps.
- retired  out  CNT_W  number of instructions completed since reset.

Behaviour:
- Reset (rst=1 at a clk edge): pc=RESET_PC, instr=0, instr_valid=0, retired=0, state=FETCH.
  - imem_req is gated to 0 while rst=1.
  - Reset has priority over every other event, including mid-FETCH and mid-HOLD. Any in-flight memory response is discarded.
- States:
  - FETCH:
    - imem_req=1, imem_addr=pc.
    - On the edge where imem_ready=1: instr<=imem_rdata, instr_valid<=1, go to HOLD.
    - Otherwise stay in FETCH; the request and address remain stable.
  - HOLD:
    - imem_req=0, instr_valid=1; instr and pc are frozen.
    - On the edge where exec_done=1: pc<=next_pc, retired<=retired+1 (wraps modulo 2^CNT_W), instr_valid<=0, go to FETCH.
- next_pc is combinational, evaluated in HOLD, with priority:
  1. PCsignal=1 and jumpSrc=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  2. PCsignal=1 and jumpSrc=0: jr_target.
  3. PCSrc=1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  4. Otherwise: pc_plus4.
  - PCsignal overrides PCSrc if both are asserted.
- Arithmetic:
  - All PC arithmetic is 32-bit, modulo 2^32; pc=32'hFFFF_FFFC wraps pc_plus4 to 0.
  - Branch offsets are signed, so backward branches are legal.
- Latency:
  - Minimum of 2 cycles per instruction: one FETCH cycle with imem_ready=1 and one HOLD cycle with exec_done=1.
  - imem_req reasserts in the cycle after exec_done is sampled.
- Input qualification:
  - exec_done is ignored in FETCH.
  - imem_ready is ignored outside FETCH.
  - PCSrc, PCsignal, jumpSrc and jr_target are only sampled on the HOLD→FETCH edge.
- pc_plus4 is always pc+4, combinational.
- Misalignment: jr_target with nonzero [1:0] is loaded as-is; there is no alignment check in this block.

Decomposition:
- Shared package mips_pkg:
  - opcode constants (OP_RTYPE 6'b000000, OP_J 6'b000010, OP_JAL 6'b000011, OP_BEQ 6'b000100, OP_BNE 6'b000101).
  - fetch state enum {FETCH, HOLD}.
  - WORD_W=32.
- One natural sub-module, mips_next_pc: purely combinational next_pc and pc_plus4 computation, so the branch/jump target logic can be unit-tested in isolation.
- The FSM, PC register, instr register and retired counter stay in the top.

Test Plan:
- Reset, then sequential fetch:
  - Stimulus: rst for 2 cycles, imem_ready=1 every cycle, exec_done=1 in every HOLD, no control asserted.
  - Required: imem_addr goes 0, 4, 8, 12; retired=3 after the third exec_done; instr_valid toggles 0/1 each cycle.
- Wait states:
  - Stimulus: imem_ready low for 3 cycles in FETCH at pc=8.
  - Required: imem_req=1 and imem_addr=8 stay stable for 4 cycles; instr updates only on the ready edge.
- Taken and not-taken branch:
  - Stimulus: pc=16, instr[15:0]=16'hFFFE, PCSrc=1.
  - Required: next imem_addr=12.
  - Stimulus: same instruction with PCSrc=0.
  - Required: next imem_addr=20.
- j and jr:
  - Stimulus: pc=32'h1000_0000, instr[25:0]=26'h0000040, PCsignal=1, jumpSrc=1.
  - Required: next imem_addr=32'h1000_0100.
  - Stimulus: PCsignal=1, jumpSrc=0, jr_target=32'h0000_0200.
  - Required: next imem_addr=32'h200.
- Priority and wrap:
  - Stimulus: PCSrc=1 and PCsignal=1, jumpSrc=0, jr_target=32'h40.
  - Required: next imem_addr=32'h40.
  - Stimulus: pc=32'hFFFF_FFFC, no control.
  - Required: next imem_addr=0.
- Reset mid-operation:
  - Stimulus: assert rst in HOLD with pc=32'h80, then assert rst in FETCH with imem_ready=1 in the same cycle.
  - Required: pc=RESET_PC, instr_valid=0, instr=0, retired=0; the memory response is not captured.
